descrambler_sync: RTL and testbench

//  Sequencer for the multiplicative descrambler in the receive chain. Gates its clock enable and issues its reset.

---
 rtl/descrambler_sync_if.sv | 26 ++
 rtl/descrambler_sync.sv | 157 +++++++++++++++
 tb/tb_descrambler_sync.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/descrambler_sync_if.sv
// rtl/descrambler_sync_if.sv - descrambler sequencer handshake and status bundle
interface descrambler_sync_if #(
    parameter int WS = 7
);
    logic          i_valid;
    logic          o_ce;
    logic          o_desc_reset;
    logic [WS-1:0] i_desc_word;
    logic          i_frame_err;
    logic          i_resync;
    logic          o_valid;
    logic [WS-1:0] o_word;
    logic          o_locked;
    logic          o_lock_lost;
    logic [1:0]    o_state;

    modport slave (
        input  i_valid, i_desc_word, i_frame_err, i_resync,
        output o_ce, o_desc_reset, o_valid, o_word, o_locked, o_lock_lost, o_state
    );

    modport master (
        output i_valid, i_desc_word, i_frame_err, i_resync,
        input  o_ce, o_desc_reset, o_valid, o_word, o_locked, o_lock_lost, o_state
    );
endinterface

// File: rtl/descrambler_sync.sv
// rtl/descrambler_sync.sv - flush/search/lock sequencer for the receive descrambler
module descrambler_sync #(
    parameter int            WS         = 7,
    parameter int            LN         = 31,
    parameter logic [WS-1:0] IDLE       = '0,
    parameter int            LOCK_WORDS = 8,
    parameter int            LOSS_ERRS  = 4,
    parameter int            WINDOW     = 64
) (
    input  logic               i_clk,
    input  logic               i_reset,
    descrambler_sync_if.slave  bus
);
    localparam int FLUSH_WORDS = (LN + WS - 1) / WS;
    localparam int FW = $clog2(FLUSH_WORDS + 1);
    localparam int MW = $clog2(LOCK_WORDS + 1);
    localparam int EW = $clog2(LOSS_ERRS + 1);
    localparam int WW = $clog2(WINDOW + 1);

    localparam logic [FW-1:0] F_LAST = FW'(FLUSH_WORDS - 1);
    localparam logic [FW-1:0] F_MAX  = FW'(FLUSH_WORDS);
    localparam logic [MW-1:0] M_LAST = MW'(LOCK_WORDS - 1);
    localparam logic [MW-1:0] M_MAX  = MW'(LOCK_WORDS);
    localparam logic [EW-1:0] E_LAST = EW'(LOSS_ERRS - 1);
    localparam logic [EW-1:0] E_MAX  = EW'(LOSS_ERRS);
    localparam logic [WW-1:0] W_LAST = WW'(WINDOW - 1);
    localparam logic [WW-1:0] W_MAX  = WW'(WINDOW);

    typedef enum logic [1:0] {
        ST_FLUSH  = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [FW-1:0] r_fcnt, w_fcnt_nxt;
    logic [MW-1:0] r_mcnt, w_mcnt_nxt;
    logic [EW-1:0] r_ecnt, w_ecnt_nxt, w_ecnt_base;
    logic [WW-1:0] r_wcnt, w_wcnt_nxt;
    logic          r_dv;
    logic          r_desc_reset;
    logic          r_valid;
    logic          r_lock_lost;
    logic [WS-1:0] r_word;
    logic          w_go_flush;
    logic          w_lost;
    logic          w_ce;

    // Words arriving while the descrambler is held in reset are discarded.
    assign w_ce = bus.i_valid & ~r_desc_reset;

    always_comb begin
        w_state_nxt = r_state;
        w_fcnt_nxt  = r_fcnt;
        w_mcnt_nxt  = r_mcnt;
        w_ecnt_nxt  = r_ecnt;
        w_wcnt_nxt  = r_wcnt;
        w_ecnt_base = r_ecnt;
        w_go_flush  = 1'b0;
        w_lost      = 1'b0;

        case (r_state)
            ST_FLUSH: begin
                if (r_dv) begin
                    if (r_fcnt != F_MAX) w_fcnt_nxt = r_fcnt + FW'(1);
                    if (r_fcnt == F_LAST) begin
                        w_state_nxt = ST_SEARCH;
                        w_mcnt_nxt  = '0;
                    end
                end
            end
            ST_SEARCH: begin
                if (r_dv) begin
                    if (bus.i_desc_word == IDLE) begin
                        if (r_mcnt != M_MAX) w_mcnt_nxt = r_mcnt + MW'(1);
                        if (r_mcnt == M_LAST) begin
                            w_state_nxt = ST_LOCKED;
                            w_ecnt_nxt  = '0;
                            w_wcnt_nxt  = '0;
                        end
                    end else begin
                        w_mcnt_nxt = '0;
                    end
                end
            end
            ST_LOCKED: begin
                // A window wrap clears the count before a same-cycle error is added.
                if (r_dv) begin
                    if (r_wcnt == W_LAST) begin
                        w_wcnt_nxt  = '0;
                        w_ecnt_base = '0;
                    end else if (r_wcnt != W_MAX) begin
                        w_wcnt_nxt = r_wcnt + WW'(1);
                    end
                end
                w_ecnt_nxt = w_ecnt_base;
                if (bus.i_frame_err) begin
                    if (w_ecnt_base != E_MAX) w_ecnt_nxt = w_ecnt_base + EW'(1);
                    if (w_ecnt_base == E_LAST) begin
                        w_go_flush = 1'b1;
                        w_lost     = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_FLUSH;
            end
        endcase

        if (bus.i_resync) begin
            w_go_flush = 1'b1;
            w_lost     = (r_state == ST_LOCKED);
        end

        if (w_go_flush) begin
            w_state_nxt = ST_FLUSH;
            w_fcnt_nxt  = '0;
            w_mcnt_nxt  = '0;
            w_ecnt_nxt  = '0;
            w_wcnt_nxt  = '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= ST_FLUSH;
            r_fcnt       <= '0;
            r_mcnt       <= '0;
            r_ecnt       <= '0;
            r_wcnt       <= '0;
            r_dv         <= 1'b0;
            r_desc_reset <= 1'b1;
            r_valid      <= 1'b0;
            r_lock_lost  <= 1'b0;
            r_word       <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_fcnt       <= w_fcnt_nxt;
            r_mcnt       <= w_mcnt_nxt;
            r_ecnt       <= w_ecnt_nxt;
            r_wcnt       <= w_wcnt_nxt;
            r_dv         <= w_ce;
            r_desc_reset <= w_go_flush;
            r_lock_lost  <= w_lost;
            r_valid      <= r_dv && (r_state == ST_LOCKED) && !w_go_flush;
            if (r_dv && (r_state == ST_LOCKED) && !w_go_flush) r_word <= bus.i_desc_word;
        end
    end

    assign bus.o_ce         = w_ce;
    assign bus.o_desc_reset = r_desc_reset;
    assign bus.o_valid      = r_valid;
    assign bus.o_word       = r_word;
    assign bus.o_locked     = (r_state == ST_LOCKED);
    assign bus.o_lock_lost  = r_lock_lost;
    assign bus.o_state      = r_state;
endmodule

// File: tb/tb_descrambler_sync.sv
// tb/tb_descrambler_sync.sv - scoreboard bench for descrambler_sync
module tb_descrambler_sync;
    localparam int WS = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    logic [WS-1:0] feed_word = '0;
    logic [WS-1:0] desc_q = '0;

    typedef struct {
        logic [WS-1:0] w;
        int            c;
    } exp_t;
    exp_t q[$];

    descrambler_sync_if #(.WS(WS)) bus ();

    descrambler_sync #(.WS(WS)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in descrambler: word appears on i_desc_word one cycle after its o_ce.
    always @(posedge clk) if (bus.o_ce === 1'b1) desc_q <= feed_word;
    assign bus.i_desc_word = desc_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && bus.o_valid === 1'b1) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_o_valid: got word %0d with none expected at cycle %0d", bus.o_word, cyc);
            end else begin
                e = q.pop_front();
                chk("o_word", 32'(bus.o_word), 32'(e.w));
                chk("o_valid_cycle", cyc, e.c);
            end
        end
    end

    task automatic step(input logic v, input logic [WS-1:0] w, input logic err,
                        input logic rs, input logic fwd);
        bus.i_valid     = v;
        feed_word       = w;
        bus.i_frame_err = err;
        bus.i_resync    = rs;
        if (fwd) q.push_back('{w: w, c: cyc + 2});
        @(posedge clk);
        #1;
        bus.i_valid     = 1'b0;
        bus.i_frame_err = 1'b0;
        bus.i_resync    = 1'b0;
    endtask

    task automatic word(input logic [WS-1:0] w, input logic fwd);
        step(1'b1, w, 1'b0, 1'b0, fwd);
    endtask
    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic err();
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    endtask
    task automatic resync();
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    endtask
    task automatic word_drop();
        bus.i_valid = 1'b1;
        feed_word   = 7'h5A;
        #1;
        chk("drop_desc_reset", 32'(bus.o_desc_reset), 1);
        chk("drop_o_ce", 32'(bus.o_ce), 0);
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
    endtask
    task automatic lock_from_flush();
        repeat (5) word(7'h6C, 1'b0);
        idle();
        repeat (8) word('0, 1'b0);
        idle();
        chk("relock", 32'(bus.o_locked), 1);
    endtask

    initial begin
        bus.i_valid     = 1'b1;
        bus.i_frame_err = 1'b0;
        bus.i_resync    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_desc_reset", 32'(bus.o_desc_reset), 1);
        chk("rst_o_ce", 32'(bus.o_ce), 0);
        chk("rst_o_valid", 32'(bus.o_valid), 0);
        chk("rst_o_word", 32'(bus.o_word), 0);
        chk("rst_o_locked", 32'(bus.o_locked), 0);
        chk("rst_o_lock_lost", 32'(bus.o_lock_lost), 0);
        chk("rst_o_state", 32'(bus.o_state), 0);
        bus.i_valid = 1'b0;
        rst = 1'b0;
        chk("rel_desc_reset_held", 32'(bus.o_desc_reset), 1);
        @(posedge clk);
        #1;
        chk("rel_desc_reset_fall", 32'(bus.o_desc_reset), 0);

        // Flush of five words, then eight idle words to lock.
        repeat (4) word(7'h3A, 1'b0);
        idle();
        chk("flush4_state", 32'(bus.o_state), 0);
        word(7'h3A, 1'b0);
        idle();
        chk("flush5_state", 32'(bus.o_state), 1);
        repeat (7) word('0, 1'b0);
        idle();
        chk("search7_locked", 32'(bus.o_locked), 0);
        word('0, 1'b0);
        idle();
        chk("search8_locked", 32'(bus.o_locked), 1);
        chk("search8_state", 32'(bus.o_state), 2);

        // Window: 3 errors, 64 words, error on the wrap cycle, 2 more -> still locked.
        err(); err(); err();
        chk("win_3err_locked", 32'(bus.o_locked), 1);
        for (int i = 0; i < 64; i++) word(WS'(i) ^ 7'h11, 1'b1);
        err();
        chk("win_wrap_locked", 32'(bus.o_locked), 1);
        err(); err();
        chk("win_new3_locked", 32'(bus.o_locked), 1);
        chk("win_new3_lost", 32'(bus.o_lock_lost), 0);
        idle();
        chk("win_q_drained", q.size(), 0);
        err();
        chk("win_loss_lost", 32'(bus.o_lock_lost), 1);
        chk("win_loss_desc_reset", 32'(bus.o_desc_reset), 1);
        chk("win_loss_state", 32'(bus.o_state), 0);
        idle();
        chk("win_lost_pulse_end", 32'(bus.o_lock_lost), 0);
        chk("win_desc_reset_end", 32'(bus.o_desc_reset), 0);

        // Search restart on a mismatch.
        repeat (5) word(7'h7F, 1'b0);
        idle();
        chk("srch_enter", 32'(bus.o_state), 1);
        repeat (6) word('0, 1'b0);
        word(7'h01, 1'b0);
        repeat (7) word('0, 1'b0);
        idle();
        chk("srch_restart_state", 32'(bus.o_state), 1);
        word('0, 1'b0);
        idle();
        chk("srch_restart_lock", 32'(bus.o_locked), 1);

        // Four errors within a few words drop lock; no output follows.
        for (int i = 0; i < 4; i++) begin
            word(WS'(7'h40 + i), 1'b1);
            idle();
            err();
        end
        chk("loss_lost", 32'(bus.o_lock_lost), 1);
        chk("loss_desc_reset", 32'(bus.o_desc_reset), 1);
        chk("loss_state", 32'(bus.o_state), 0);
        chk("loss_locked", 32'(bus.o_locked), 0);
        word_drop();
        chk("loss_desc_reset_1cyc", 32'(bus.o_desc_reset), 0);
        repeat (2) word(7'h15, 1'b0);
        idle();
        chk("loss_no_valid", 32'(bus.o_valid), 0);

        // Resync from SEARCH: reset pulse but no lock_lost; then 1-in-3 duty lock.
        repeat (3) word(7'h15, 1'b0);
        idle();
        chk("rs_search_state", 32'(bus.o_state), 1);
        resync();
        chk("rs_search_desc_reset", 32'(bus.o_desc_reset), 1);
        chk("rs_search_lost", 32'(bus.o_lock_lost), 0);
        chk("rs_search_to_flush", 32'(bus.o_state), 0);
        word_drop();
        repeat (4) begin word(7'h22, 1'b0); idle(); idle(); end
        chk("duty_flush4", 32'(bus.o_state), 0);
        word(7'h22, 1'b0); idle(); idle();
        chk("duty_flush5", 32'(bus.o_state), 1);
        repeat (7) begin word('0, 1'b0); idle(); idle(); end
        chk("duty_search7", 32'(bus.o_locked), 0);
        word('0, 1'b0); idle(); idle();
        chk("duty_search8", 32'(bus.o_locked), 1);

        // Resync from LOCKED pulses lock_lost.
        resync();
        chk("rs_locked_lost", 32'(bus.o_lock_lost), 1);
        chk("rs_locked_desc_reset", 32'(bus.o_desc_reset), 1);
        chk("rs_locked_locked", 32'(bus.o_locked), 0);
        idle();
        lock_from_flush();

        // Data, o_word hold, then async reset mid-LOCKED.
        word(7'h61, 1'b1);
        word(7'h62, 1'b1);
        repeat (3) idle();
        chk("hold_o_valid", 32'(bus.o_valid), 0);
        chk("hold_o_word", 32'(bus.o_word), 32'h62);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_desc_reset", 32'(bus.o_desc_reset), 1);
        chk("arst_o_word", 32'(bus.o_word), 0);
        chk("arst_o_locked", 32'(bus.o_locked), 0);
        chk("arst_o_state", 32'(bus.o_state), 0);
        chk("arst_o_valid", 32'(bus.o_valid), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("arst_rel_held", 32'(bus.o_desc_reset), 1);
        @(posedge clk);
        #1;
        chk("arst_rel_fall", 32'(bus.o_desc_reset), 0);
        chk("end_q_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
